// File: rtl/bcpu_dualport_bram_be.sv
// Dual-port block RAM for bcpu cores with byte write enables, per-port read latency,
// selectable same-port read-during-write behaviour, read-valid strobes and collision flag.
module bcpu_dualport_bram_be #(
  parameter int    DATA_WIDTH = 32,
  parameter int    BYTE_WIDTH = 8,
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = "",
  parameter int    A_LATENCY  = 2,
  parameter int    B_LATENCY  = 2,
  parameter string RDW_MODE   = "READ_FIRST"
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic                               CE,
  input  logic                               PORT_A_EN,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   PORT_A_WE,
  input  logic [ADDR_WIDTH-1:0]              PORT_A_ADDR,
  input  logic [DATA_WIDTH-1:0]              PORT_A_WRDATA,
  output logic [DATA_WIDTH-1:0]              PORT_A_RDDATA,
  output logic                               PORT_A_RDVALID,
  input  logic                               PORT_B_EN,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   PORT_B_WE,
  input  logic [ADDR_WIDTH-1:0]              PORT_B_ADDR,
  input  logic [DATA_WIDTH-1:0]              PORT_B_WRDATA,
  output logic [DATA_WIDTH-1:0]              PORT_B_RDDATA,
  output logic                               PORT_B_RDVALID,
  output logic                               COLLISION
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST,
    RDW_NO_CHANGE,
    RDW_INVALID
  } rdw_e;

  localparam rdw_e RDW = (RDW_MODE == "READ_FIRST")  ? RDW_READ_FIRST  :
                         (RDW_MODE == "WRITE_FIRST") ? RDW_WRITE_FIRST :
                         (RDW_MODE == "NO_CHANGE")   ? RDW_NO_CHANGE   : RDW_INVALID;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (A_LATENCY != 1 && A_LATENCY != 2) begin : g_bad_a_lat
    $error("A_LATENCY must be 1 or 2");
  end
  if (B_LATENCY != 1 && B_LATENCY != 2) begin : g_bad_b_lat
    $error("B_LATENCY must be 1 or 2");
  end
  if (RDW == RDW_INVALID) begin : g_bad_rdw
    $error("RDW_MODE must be READ_FIRST, WRITE_FIRST or NO_CHANGE");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         we
  );
    merge_word = old_w;
    for (int unsigned i = 0; i < NB; i++)
      if (we[i]) merge_word[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  logic                  a_wr, b_wr, a_cap, b_cap, a_s1_vld, b_s1_vld;
  logic [DATA_WIDTH-1:0] a_cap_data, b_cap_data, a_s1_data, b_s1_data;

  // A write that is not captured (NO_CHANGE) leaves the read path untouched.
  always_comb begin
    a_wr       = PORT_A_EN && (|PORT_A_WE);
    b_wr       = PORT_B_EN && (|PORT_B_WE);
    a_cap      = PORT_A_EN && !(a_wr && RDW == RDW_NO_CHANGE);
    b_cap      = PORT_B_EN && !(b_wr && RDW == RDW_NO_CHANGE);
    a_cap_data = mem[PORT_A_ADDR];
    b_cap_data = mem[PORT_B_ADDR];
    if (a_wr && RDW == RDW_WRITE_FIRST)
      a_cap_data = merge_word(mem[PORT_A_ADDR], PORT_A_WRDATA, PORT_A_WE);
    if (b_wr && RDW == RDW_WRITE_FIRST)
      b_cap_data = merge_word(mem[PORT_B_ADDR], PORT_B_WRDATA, PORT_B_WE);
  end

  // Port A lane writes are issued after port B so A wins on a shared lane.
  always_ff @(posedge CLK) begin
    if (CE) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (PORT_B_EN && PORT_B_WE[i])
          mem[PORT_B_ADDR][i*BYTE_WIDTH +: BYTE_WIDTH] <= PORT_B_WRDATA[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (PORT_A_EN && PORT_A_WE[i])
          mem[PORT_A_ADDR][i*BYTE_WIDTH +: BYTE_WIDTH] <= PORT_A_WRDATA[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_s1_vld       <= 1'b0;
      a_s1_data      <= '0;
      PORT_A_RDVALID <= 1'b0;
      PORT_A_RDDATA  <= '0;
    end else if (CE) begin
      a_s1_vld <= a_cap;
      if (a_cap) a_s1_data <= a_cap_data;
      if (A_LATENCY == 1) begin
        PORT_A_RDVALID <= a_cap;
        if (a_cap) PORT_A_RDDATA <= a_cap_data;
      end else begin
        PORT_A_RDVALID <= a_s1_vld;
        if (a_s1_vld) PORT_A_RDDATA <= a_s1_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      b_s1_vld       <= 1'b0;
      b_s1_data      <= '0;
      PORT_B_RDVALID <= 1'b0;
      PORT_B_RDDATA  <= '0;
    end else if (CE) begin
      b_s1_vld <= b_cap;
      if (b_cap) b_s1_data <= b_cap_data;
      if (B_LATENCY == 1) begin
        PORT_B_RDVALID <= b_cap;
        if (b_cap) PORT_B_RDDATA <= b_cap_data;
      end else begin
        PORT_B_RDVALID <= b_s1_vld;
        if (b_s1_vld) PORT_B_RDDATA <= b_s1_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COLLISION <= 1'b0;
    end else if (CE) begin
      COLLISION <= PORT_A_EN && PORT_B_EN && (PORT_A_ADDR == PORT_B_ADDR) && (a_wr || b_wr);
    end
  end

endmodule

// File: tb/tb_bcpu_dualport_bram_be.sv
// Bench for bcpu_dualport_bram_be: three instances (one per read-during-write mode)
// share stimulus and are checked every cycle against a queue-based memory model.
module tb_bcpu_dualport_bram_be;

  localparam int A_LAT = 2;
  localparam int B_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n, ce;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [11:0] addr_a, addr_b;
  logic [31:0] wd_a, wd_b;

  logic [31:0] rd_a [3];
  logic [31:0] rd_b [3];
  logic        va [3];
  logic        vb [3];
  logic        coll [3];

  int checks = 0;
  int errors = 0;
  string mname [3] = '{"rf", "wf", "nc"};

  always #5 clk = ~clk;

  bcpu_dualport_bram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(12), .INIT_FILE(""),
    .A_LATENCY(A_LAT), .B_LATENCY(B_LAT), .RDW_MODE("READ_FIRST")) u_rf (
    .CLK(clk), .RESET_N(rst_n), .CE(ce),
    .PORT_A_EN(en_a), .PORT_A_WE(we_a), .PORT_A_ADDR(addr_a), .PORT_A_WRDATA(wd_a),
    .PORT_A_RDDATA(rd_a[0]), .PORT_A_RDVALID(va[0]),
    .PORT_B_EN(en_b), .PORT_B_WE(we_b), .PORT_B_ADDR(addr_b), .PORT_B_WRDATA(wd_b),
    .PORT_B_RDDATA(rd_b[0]), .PORT_B_RDVALID(vb[0]), .COLLISION(coll[0]));

  bcpu_dualport_bram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(12), .INIT_FILE(""),
    .A_LATENCY(A_LAT), .B_LATENCY(B_LAT), .RDW_MODE("WRITE_FIRST")) u_wf (
    .CLK(clk), .RESET_N(rst_n), .CE(ce),
    .PORT_A_EN(en_a), .PORT_A_WE(we_a), .PORT_A_ADDR(addr_a), .PORT_A_WRDATA(wd_a),
    .PORT_A_RDDATA(rd_a[1]), .PORT_A_RDVALID(va[1]),
    .PORT_B_EN(en_b), .PORT_B_WE(we_b), .PORT_B_ADDR(addr_b), .PORT_B_WRDATA(wd_b),
    .PORT_B_RDDATA(rd_b[1]), .PORT_B_RDVALID(vb[1]), .COLLISION(coll[1]));

  bcpu_dualport_bram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(12), .INIT_FILE(""),
    .A_LATENCY(A_LAT), .B_LATENCY(B_LAT), .RDW_MODE("NO_CHANGE")) u_nc (
    .CLK(clk), .RESET_N(rst_n), .CE(ce),
    .PORT_A_EN(en_a), .PORT_A_WE(we_a), .PORT_A_ADDR(addr_a), .PORT_A_WRDATA(wd_a),
    .PORT_A_RDDATA(rd_a[2]), .PORT_A_RDVALID(va[2]),
    .PORT_B_EN(en_b), .PORT_B_WE(we_b), .PORT_B_ADDR(addr_b), .PORT_B_WRDATA(wd_b),
    .PORT_B_RDDATA(rd_b[2]), .PORT_B_RDVALID(vb[2]), .COLLISION(coll[2]));

  // ---------------- behavioural model ----------------
  typedef struct {
    int          done_at;
    logic [31:0] data;
  } pend_t;

  logic [31:0] mmem [int];
  pend_t       qa [3][$];
  pend_t       qb [3][$];
  logic        mva [3] = '{1'b0, 1'b0, 1'b0};
  logic        mvb [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] mda [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] mdb [3] = '{32'h0, 32'h0, 32'h0};
  logic        mcoll = 1'b0;
  int          nedge = 0;

  function automatic logic [31:0] mrd(input int a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    pend_t       p;
    logic [31:0] oa, ob;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        qa[k].delete(); qb[k].delete();
        mva[k] = 1'b0; mvb[k] = 1'b0; mda[k] = 32'h0; mdb[k] = 32'h0;
      end
      mcoll = 1'b0;
    end else if (ce) begin
      oa = mrd(int'(addr_a));
      ob = mrd(int'(addr_b));
      for (int k = 0; k < 3; k++) begin
        if (en_a && (we_a == 4'h0 || k != 2)) begin
          p.done_at = nedge + A_LAT - 1;
          p.data    = (we_a != 4'h0 && k == 1) ? merge(oa, wd_a, we_a) : oa;
          qa[k].push_back(p);
        end
        if (en_b && (we_b == 4'h0 || k != 2)) begin
          p.done_at = nedge + B_LAT - 1;
          p.data    = (we_b != 4'h0 && k == 1) ? merge(ob, wd_b, we_b) : ob;
          qb[k].push_back(p);
        end
        mva[k] = 1'b0;
        if (qa[k].size() != 0 && qa[k][0].done_at == nedge) begin
          p = qa[k].pop_front(); mva[k] = 1'b1; mda[k] = p.data;
        end
        mvb[k] = 1'b0;
        if (qb[k].size() != 0 && qb[k][0].done_at == nedge) begin
          p = qb[k].pop_front(); mvb[k] = 1'b1; mdb[k] = p.data;
        end
      end
      mcoll = en_a && en_b && (addr_a == addr_b) && (we_a != 4'h0 || we_b != 4'h0);
      if (en_b && we_b != 4'h0) mmem[int'(addr_b)] = merge(ob, wd_b, we_b);
      if (en_a && we_a != 4'h0) mmem[int'(addr_a)] = merge(mrd(int'(addr_a)), wd_a, we_a);
      nedge++;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk({mname[k], ".A_RDVALID"}, 32'(va[k]), 32'(mva[k]));
      chk({mname[k], ".A_RDDATA"},  rd_a[k],    mda[k]);
      chk({mname[k], ".B_RDVALID"}, 32'(vb[k]), 32'(mvb[k]));
      chk({mname[k], ".B_RDDATA"},  rd_b[k],    mdb[k]);
      chk({mname[k], ".COLLISION"}, 32'(coll[k]), 32'(mcoll));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic drive(input logic ea, input logic [3:0] wa, input int aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input int ab, input logic [31:0] db);
    en_a = ea; we_a = wa; addr_a = 12'(aa); wd_a = da;
    en_b = eb; we_b = wb; addr_b = 12'(ab); wd_b = db;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
  endtask

  function automatic logic [31:0] tdata(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; ce = 1'b1; idle();
    cyc(); cyc();
    chk("reset_rddata_a", rd_a[0], 32'h0);
    chk("reset_rdvalid_b", 32'(vb[0]), 32'h0);
    chk("reset_collision", 32'(coll[0]), 32'h0);
    rst_n = 1'b1;
    cyc();

    // byte-lane writes then reads on both ports
    drive(1'b1, 4'hF, 5, 32'h1122_3344, 1'b0, 4'h0, 0, 32'h0); cyc();
    drive(1'b1, 4'h2, 5, 32'hAABB_CCDD, 1'b0, 4'h0, 0, 32'h0); cyc();
    drive(1'b1, 4'h0, 5, 32'h0, 1'b1, 4'h0, 5, 32'h0); cyc();
    chk("byte_b_valid_lat1", 32'(vb[0]), 32'h1);
    chk("byte_b_data", rd_b[0], 32'h1122_CC44);
    chk("byte_a_not_early", 32'(va[2]), 32'h0);
    idle(); cyc();
    chk("byte_a_valid_lat2", 32'(va[0]), 32'h1);
    chk("byte_a_data", rd_a[0], 32'h1122_CC44);
    chk("byte_b_pulse_end", 32'(vb[0]), 32'h0);
    cyc();
    chk("byte_a_pulse_end", 32'(va[0]), 32'h0);

    // reset while a 2-latency read is in flight
    drive(1'b1, 4'h0, 5, 32'h0, 1'b0, 4'h0, 0, 32'h0); cyc();
    rst_n = 1'b0; idle(); #1;
    chk("rst_async_rddata", rd_a[0], 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_no_stale_valid0", 32'(va[0]), 32'h0);
    cyc();
    chk("rst_no_stale_valid1", 32'(va[0]), 32'h0);

    // read-during-write modes on addr 7 (holds 0)
    drive(1'b1, 4'h0, 5, 32'h0, 1'b0, 4'h0, 0, 32'h0); cyc();
    idle(); cyc(); cyc();
    drive(1'b1, 4'hF, 7, 32'hFFFF_FFFF, 1'b0, 4'h0, 0, 32'h0); cyc();
    idle(); cyc();
    chk("rdw_rf_valid", 32'(va[0]), 32'h1);
    chk("rdw_rf_data", rd_a[0], 32'h0);
    chk("rdw_wf_valid", 32'(va[1]), 32'h1);
    chk("rdw_wf_data", rd_a[1], 32'hFFFF_FFFF);
    chk("rdw_nc_valid", 32'(va[2]), 32'h0);
    chk("rdw_nc_hold", rd_a[2], 32'h1122_CC44);

    // dual write to addr 3, A wins on shared lane
    drive(1'b1, 4'h1, 3, 32'h0000_00AA, 1'b1, 4'h3, 3, 32'h0000_BB55); cyc();
    chk("coll_ww_pulse", 32'(coll[0]), 32'h1);
    idle(); cyc();
    chk("coll_ww_end", 32'(coll[0]), 32'h0);
    drive(1'b1, 4'h0, 3, 32'h0, 1'b0, 4'h0, 0, 32'h0); cyc();
    idle(); cyc();
    chk("coll_merge_data", rd_a[0], 32'h0000_BBAA);

    // cross-port read/write on addr 9
    drive(1'b1, 4'hF, 9, 32'h1234_5678, 1'b0, 4'h0, 0, 32'h0); cyc();
    drive(1'b1, 4'h0, 9, 32'h0, 1'b1, 4'hF, 9, 32'hCAFE_F00D); cyc();
    chk("coll_rw_pulse", 32'(coll[0]), 32'h1);
    idle(); cyc();
    chk("cross_old_word", rd_a[0], 32'h1234_5678);
    drive(1'b1, 4'h0, 9, 32'h0, 1'b0, 4'h0, 0, 32'h0); cyc();
    idle(); cyc();
    chk("cross_new_word", rd_a[0], 32'hCAFE_F00D);

    // clock-enable stall with a read in flight on A and a completed read on B
    drive(1'b1, 4'h0, 5, 32'h0, 1'b1, 4'h0, 3, 32'h0); cyc();
    chk("stall_b_valid", 32'(vb[0]), 32'h1);
    chk("stall_b_data", rd_b[0], 32'h0000_BBAA);
    ce = 1'b0; idle();
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("stall_b_hold", 32'(vb[0]), 32'h1);
      chk("stall_a_no_valid", 32'(va[0]), 32'h0);
      chk("stall_a_hold", rd_a[0], 32'hCAFE_F00D);
    end
    ce = 1'b1; cyc();
    chk("stall_a_valid", 32'(va[0]), 32'h1);
    chk("stall_a_data", rd_a[0], 32'h1122_CC44);
    chk("stall_b_end", 32'(vb[0]), 32'h0);

    // full-throughput reads of 16 consecutive addresses
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 4'hF, i, tdata(i)); cyc();
    end
    idle(); cyc(); cyc();
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive(1'b1, 4'h0, i, 32'h0, 1'b0, 4'h0, 0, 32'h0);
      else idle();
      cyc();
      if (i == 0) chk("thru_first_idle", 32'(va[0]), 32'h0);
      else begin
        chk("thru_valid", 32'(va[0]), 32'h1);
        chk("thru_data", rd_a[0], tdata(i - 1));
      end
    end
    idle(); cyc();
    chk("thru_tail_idle", 32'(va[0]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
